// File: rtl/piso_tx_sched_pkg.sv
// Shared definitions for the two-requester PISO transmit scheduler.
//   state_e          : FSM state encoding (IDLE / SHIFT / GAP)
//   REQ0 / REQ1      : requester identifiers as carried on grant_id
//   DEFAULT_WIDTH    : default word width
//   DEFAULT_GAP      : default idle cycles after each frame
//   gap_cnt_w()      : width of the gap counter, never below one bit
package piso_tx_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_GAP   = 1;

  // A zero-length gap still needs a legal (one-bit) counter declaration.
  function automatic int gap_cnt_w(input int gap);
    return ($clog2(gap + 1) < 1) ? 1 : $clog2(gap + 1);
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// Parallel-in / serial-out shift register, MSB first.
//   clk, rst : clock and synchronous active-high reset
//   load     : capture din (wins over shift)
//   shift    : shift left by one, filling with 0
//   din      : parallel word
//   dout     : current MSB
module piso_shreg
  import piso_tx_sched_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             dout
);

  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_d;

  always_comb begin
    sh_d = sh_q;
    if (load) begin
      sh_d = din;
    end else if (shift) begin
      sh_d = {sh_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign dout = sh_q[WIDTH-1];

endmodule

// File: rtl/piso_tx_sched.sv
// Round-robin scheduler for two word sources feeding one serial line.
// A granted word is loaded on the handshake edge and shifted out MSB first,
// framed by ser_valid / frame_start / frame_done, followed by GAP idle cycles.
//   clk, rst                 : clock, synchronous active-high reset
//   reqN_valid/data/ready    : per-requester valid/ready word interface
//   ser_out, ser_valid       : serial bit and its qualifier
//   frame_start, frame_done  : pulses on the first and last bit of a frame
//   grant_id                 : owner of the current/last frame
//   busy                     : high whenever the FSM is not idle
module piso_tx_sched
  import piso_tx_sched_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int GAP   = DEFAULT_GAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             grant_id,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int GAP_W = gap_cnt_w(GAP);

  localparam logic [CNT_W-1:0] LAST_BIT     = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] PREV_TO_LAST = CNT_W'(WIDTH - 2);
  localparam logic [GAP_W-1:0] LAST_GAP     = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             prio_q, prio_d;
  logic             grant_q, grant_d;
  logic             ser_valid_q, ser_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;

  logic             gnt;
  logic             hs;
  logic             shreg_dout;
  logic [WIDTH-1:0] load_word;

  // Arbiter: the priority holder only matters when both sources are valid.
  // Ready is suppressed during reset so no word is lost into a clearing shifter.
  always_comb begin
    if (req0_valid && req1_valid) begin
      gnt = prio_q;
    end else if (req1_valid) begin
      gnt = REQ1;
    end else begin
      gnt = REQ0;
    end
    hs = (state_q == ST_IDLE) && !rst && (req0_valid || req1_valid);
  end

  assign req0_ready = hs && (gnt == REQ0);
  assign req1_ready = hs && (gnt == REQ1);
  assign load_word  = (gnt == REQ1) ? req1_data : req0_data;

  piso_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (hs),
    .shift (state_q == ST_SHIFT),
    .din   (load_word),
    .dout  (shreg_dout)
  );

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    prio_d        = prio_q;
    grant_d       = grant_q;
    ser_valid_d   = ser_valid_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    busy_d        = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          state_d       = ST_SHIFT;
          bit_cnt_d     = '0;
          grant_d       = gnt;
          prio_d        = ~gnt;
          ser_valid_d   = 1'b1;
          frame_start_d = 1'b1;
          busy_d        = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_q == LAST_BIT) begin
          ser_valid_d = 1'b0;
          gap_cnt_d   = '0;
          if (GAP > 0) begin
            state_d = ST_GAP;
            busy_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          bit_cnt_d    = bit_cnt_q + CNT_W'(1);
          // Strobes are registered, so raise frame_done one bit early.
          frame_done_d = (bit_cnt_q == PREV_TO_LAST);
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == LAST_GAP) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: begin
        state_d     = ST_IDLE;
        ser_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      prio_q        <= REQ0;
      grant_q       <= REQ0;
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      prio_q        <= prio_d;
      grant_q       <= grant_d;
      ser_valid_q   <= ser_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      busy_q        <= busy_d;
    end
  end

  // The shifter drains to zero after the last bit, but gate anyway so the
  // line is guaranteed quiet outside a frame.
  assign ser_out     = ser_valid_q & shreg_dout;
  assign ser_valid   = ser_valid_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign grant_id    = grant_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_piso_tx_sched.sv
module tb_piso_tx_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: GAP=1, instance B: GAP=0. Both WIDTH=4, shared clk/rst.
  logic       a_v0, a_v1, a_r0, a_r1, a_so, a_sv, a_fs, a_fd, a_gid, a_busy;
  logic [3:0] a_d0, a_d1;
  logic       b_v0, b_v1, b_r0, b_r1, b_so, b_sv, b_fs, b_fd, b_gid, b_busy;
  logic [3:0] b_d0, b_d1;

  piso_tx_sched #(.WIDTH(4), .GAP(1)) dut_a (
    .clk(clk), .rst(rst),
    .req0_valid(a_v0), .req0_data(a_d0), .req0_ready(a_r0),
    .req1_valid(a_v1), .req1_data(a_d1), .req1_ready(a_r1),
    .ser_out(a_so), .ser_valid(a_sv), .frame_start(a_fs), .frame_done(a_fd),
    .grant_id(a_gid), .busy(a_busy)
  );

  piso_tx_sched #(.WIDTH(4), .GAP(0)) dut_b (
    .clk(clk), .rst(rst),
    .req0_valid(b_v0), .req0_data(b_d0), .req0_ready(b_r0),
    .req1_valid(b_v1), .req1_data(b_d1), .req1_ready(b_r1),
    .ser_out(b_so), .ser_valid(b_sv), .frame_start(b_fs), .frame_done(b_fd),
    .grant_id(b_gid), .busy(b_busy)
  );

  typedef struct packed {
    logic b;
    logic gid;
    logic fs;
    logic fd;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected serial bits of one frame, MSB first; nbits < 4 models an abort.
  task automatic push_frame(input bit sel, input logic [3:0] w, input logic gid, input int nbits);
    exp_t e;
    for (int i = 0; i < nbits; i++) begin
      e.b   = w[3-i];
      e.gid = gid;
      e.fs  = (i == 0);
      e.fd  = (i == 3);
      if (sel) qb.push_back(e);
      else     qa.push_back(e);
    end
  endtask

  // Wait for a ready on the selected instance, check which port got it,
  // then step past the handshake edge.
  task automatic wait_hs(input bit sel, input logic exp_port, output int waited, output int at_cyc);
    logic r0, r1;
    bit   got;
    got    = 0;
    waited = 0;
    at_cyc = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      r0 = sel ? b_r0 : a_r0;
      r1 = sel ? b_r1 : a_r1;
      if (r0 || r1) begin
        got    = 1;
        waited = i;
        chk("hs_port", 32'(r1), 32'(exp_port));
        $display("t=%0t dut_%s handshake on req%0d", $time, sel ? "b" : "a", r1 ? 1 : 0);
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL hs_timeout: got no ready, expected ready on req%0d", exp_port);
    end else begin
      @(posedge clk);
      #1;
      at_cyc = cyc;
    end
  endtask

  // Scoreboard monitors: pop one expected bit per ser_valid cycle.
  always @(negedge clk) begin
    chk("a_ready_excl", 32'(a_r0 & a_r1), 32'd0);
    if (a_sv) begin
      if (qa.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL a_unexpected_bit: got ser_valid=1, expected idle line");
      end else begin
        ea = qa.pop_front();
        chk("a_ser_out", 32'(a_so), 32'(ea.b));
        chk("a_grant_id", 32'(a_gid), 32'(ea.gid));
        chk("a_frame_start", 32'(a_fs), 32'(ea.fs));
        chk("a_frame_done", 32'(a_fd), 32'(ea.fd));
      end
    end else begin
      chk("a_idle_line", 32'({a_so, a_fs, a_fd}), 32'd0);
    end
  end

  always @(negedge clk) begin
    chk("b_ready_excl", 32'(b_r0 & b_r1), 32'd0);
    if (b_sv) begin
      if (qb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL b_unexpected_bit: got ser_valid=1, expected idle line");
      end else begin
        eb = qb.pop_front();
        chk("b_ser_out", 32'(b_so), 32'(eb.b));
        chk("b_grant_id", 32'(b_gid), 32'(eb.gid));
        chk("b_frame_start", 32'(b_fs), 32'(eb.fs));
        chk("b_frame_done", 32'(b_fd), 32'(eb.fd));
      end
    end else begin
      chk("b_idle_line", 32'({b_so, b_fs, b_fd}), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, c, prev;
    a_v0 = 0; a_v1 = 0; a_d0 = '0; a_d1 = '0;
    b_v0 = 0; b_v1 = 0; b_d0 = '0; b_d1 = '0;
    rst  = 1;

    // Reset state, with a request pending that must not see ready.
    repeat (2) @(posedge clk);
    #1;
    a_v0 = 1; a_d0 = 4'hF;
    @(negedge clk);
    chk("rst_req0_ready", 32'(a_r0), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_ser_valid", 32'(a_sv), 32'd0);
    chk("rst_grant_id", 32'(a_gid), 32'd0);
    chk("rst_b_busy", 32'(b_busy), 32'd0);

    // Test 1: req0 alone, 4'hF; busy covers the 4 bits plus 1 gap cycle.
    push_frame(0, 4'hF, 1'b0, 4);
    @(posedge clk);
    #1;
    rst = 0;
    wait_hs(0, 1'b0, w, c);
    chk("t1_ready_immediate", 32'(w), 32'd0);
    a_v0 = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("t1_busy", 32'(a_busy), 32'd1);
    end
    chk("t1_gap_sv", 32'(a_sv), 32'd0);
    @(negedge clk);
    chk("t1_idle_busy", 32'(a_busy), 32'd0);
    @(posedge clk);
    #1;

    // Test 2: req1 alone, 4'h5.
    push_frame(0, 4'h5, 1'b1, 4);
    a_v1 = 1; a_d1 = 4'h5;
    wait_hs(0, 1'b1, w, c);
    a_v1 = 0;
    repeat (8) @(posedge clk);
    #1;

    // Test 3: fresh reset, both valid: strict alternation, 6-cycle spacing.
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    push_frame(0, 4'hA, 1'b0, 4);
    push_frame(0, 4'h3, 1'b1, 4);
    push_frame(0, 4'hA, 1'b0, 4);
    push_frame(0, 4'h3, 1'b1, 4);
    a_v0 = 1; a_d0 = 4'hA;
    a_v1 = 1; a_d1 = 4'h3;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_hs(0, logic'(k % 2), w, c);
      if (k > 0) chk("t3_spacing", 32'(c - prev), 32'd6);
      prev = c;
    end
    a_v0 = 0; a_v1 = 0;
    repeat (7) @(posedge clk);
    #1;

    // Test 4: req1 raises valid during bit 2 of a req0 frame.
    push_frame(0, 4'h7, 1'b0, 4);
    push_frame(0, 4'hC, 1'b1, 4);
    a_v0 = 1; a_d0 = 4'h7;
    wait_hs(0, 1'b0, w, c);
    a_v0 = 0;
    @(posedge clk);
    #1;
    a_v1 = 1; a_d1 = 4'hC;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t4_no_ready_busy", 32'(a_r1), 32'd0);
    end
    wait_hs(0, 1'b1, w, c);
    chk("t4_ready_first_idle", 32'(w), 32'd0);
    a_v1 = 0;
    repeat (7) @(posedge clk);
    #1;

    // Test 5: reset during bit 1 of a 4'h9 frame; only 3 bits emerge.
    push_frame(0, 4'h9, 1'b0, 3);
    a_v0 = 1; a_d0 = 4'h9;
    wait_hs(0, 1'b0, w, c);
    a_v0 = 0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("t5_sv_after_rst", 32'(a_sv), 32'd0);
    chk("t5_so_after_rst", 32'(a_so), 32'd0);
    chk("t5_busy_after_rst", 32'(a_busy), 32'd0);
    chk("t5_gid_after_rst", 32'(a_gid), 32'd0);
    @(posedge clk);
    #1;
    push_frame(0, 4'h2, 1'b0, 4);
    a_v0 = 1; a_d0 = 4'h2;
    a_v1 = 1; a_d1 = 4'hE;
    wait_hs(0, 1'b0, w, c);
    a_v0 = 0; a_v1 = 0;
    repeat (7) @(posedge clk);
    #1;

    // Test 6: GAP=0 instance, req0 held valid: frames every 5 cycles.
    push_frame(1, 4'h6, 1'b0, 4);
    push_frame(1, 4'h6, 1'b0, 4);
    push_frame(1, 4'h6, 1'b0, 4);
    b_v0 = 1; b_d0 = 4'h6;
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      wait_hs(1, 1'b0, w, c);
      if (k > 0) chk("t6_spacing", 32'(c - prev), 32'd5);
      prev = c;
    end
    b_v0 = 0;
    repeat (8) @(posedge clk);
    #1;

    chk("qa_drained", 32'(qa.size()), 32'd0);
    chk("qb_drained", 32'(qb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_tx_sched.md
Name: piso_tx_sched

Overview:
Two-requester scheduler and sequencer for a WIDTH-bit parallel-in/serial-out shifter.
- Arbitrates round-robin between two word sources using valid/ready handshakes.
- Loads the granted word into an internal shifter and shifts it out MSB-first, one bit per clock.
- Frames each word with ser_valid, frame_start and frame_done strobes, then enforces a programmable idle gap.
- Sits between producer logic and any single-wire serial consumer.

Parameters:
WIDTH, 4, word width in bits; must be >= 2.
GAP, 1, extra idle cycles after each frame before the next grant; 0 is legal.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous reset, active-high.
req0_valid  input  1  requester 0 has a word.
req0_data  input  WIDTH  requester 0 word; stable while req0_valid is high.
req0_ready  output  1  handshake for requester 0; the word transfers on the edge where valid and ready are both high.
req1_valid  input  1  requester 1 has a word.
req1_data  input  WIDTH  requester 1 word.
req1_ready  output  1  handshake for requester 1.
ser_out  output  1  serial data, MSB first; 0 when ser_valid is low.
ser_valid  output  1  high during every bit cycle of a frame.
frame_start  output  1  one-cycle pulse during bit WIDTH-1, the first bit out.
frame_done  output  1  one-cycle pulse during bit 0, the last bit out.
grant_id  output  1  requester that owns the current frame; holds its last value when idle.
busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset: clk and rst are the only clock and reset. Reset is synchronous and active-high.
  - State goes to IDLE; shifter, bit counter and gap counter go to 0.
  - ser_out, ser_valid, frame_start, frame_done, busy and grant_id go to 0.
  - Round-robin priority goes to requester 0.
  - reqN_ready is forced to 0 in any cycle where rst is high.
- States:
  - IDLE -> LOAD never exists as a separate cycle; the load happens on the handshake edge.
  - IDLE -> SHIFT on a handshake.
  - SHIFT -> GAP after WIDTH bit cycles when GAP > 0.
  - SHIFT -> IDLE after WIDTH bit cycles when GAP = 0.
  - GAP -> IDLE after GAP cycles.
- Ready is combinational and only asserted in IDLE.
  - Only one valid: that requester gets ready.
  - Both valid: the priority holder gets ready.
  - At most one ready per cycle; the two readys are never high together.
- Handshake at edge N:
  - Word loads into the shifter; grant_id latches; priority passes to the other requester.
  - The next state is SHIFT.
- SHIFT: ser_valid=1 for cycles N+1 to N+WIDTH, and ser_out = shifter MSB.
  - The shifter shifts left with 0 fill each cycle.
  - Bit counter counts from 0 to WIDTH-1.
- Frame spacing: ser_valid is low for exactly GAP+1 cycles between back-to-back frames, because IDLE lasts at least one cycle.
- Valid asserted while busy: no ready is given. The requester holds valid and data, and the request is arbitrated in the first IDLE cycle.
- Valid dropping without ready: no transfer, no state change. Dropping valid without ready is a source protocol error but must be tolerated.
- Reset mid-frame: the frame is aborted and its remaining bits are discarded. The word was already accepted, so it is lost and no re-request is generated. All outputs take reset values on the next edge.
- Counter widths:
  - Bit counter is $clog2(WIDTH) bits.
  - Gap counter is max(1,$clog2(GAP+1)) bits.
  - No wrap-around is observable, because counters reload on state entry.

Decomposition:
- Shared package holds:
  - State encoding constants IDLE=2'd0, SHIFT=2'd1, GAP=2'd2.
  - Requester id constants REQ0=1'b0, REQ1=1'b1.
  - Default WIDTH and GAP values.
- One sub-module, piso_shreg (WIDTH; clk, rst, load, shift, din[WIDTH], dout):
  - Synchronous active-high reset.
  - load has priority over shift.
  - dout is the MSB.
- Arbiter, FSM and counters stay in piso_tx_sched.

Test Plan:
1. WIDTH=4, GAP=1. Release reset, then req0_valid=1 with data 4'hF.
   -> req0_ready for one cycle; ser_out 1,1,1,1 with ser_valid high for 4 cycles.
   -> frame_start on cycle 1 and frame_done on cycle 4; grant_id=0; busy high through the gap.
2. req1 alone with 4'h5.
   -> ser_out 0,1,0,1; grant_id=1; ser_valid low for exactly 2 cycles before the next possible frame.
3. After reset, both requesters valid with req0=4'hA and req1=4'h3, reloading the same data after each ready for 4 frames.
   -> Order is req0,req1,req0,req1; serial stream is 1010,0011,1010,0011; the two readys are never high in the same cycle.
4. req1 asserts 4'hC during bit 2 of a req0 frame.
   -> req1_ready stays 0 until the first IDLE cycle; then frame 1100 follows with no ready glitches.
5. rst pulsed for 1 cycle during bit 1 of a 4'h9 frame.
   -> Next cycle ser_valid=0, ser_out=0, busy=0, frame_done never fires; priority is back to req0, so with both valid req0 wins next.
6. Instance with GAP=0 and req0 continuously valid with 4'h6.
   -> Frames 0110 repeat with exactly one ser_valid-low cycle between them.
